// File: rtl/instr_encoder_loader.sv
// -----------------------------------------------------------------------------
// instr_encoder_loader
//
// Purpose: builds RV32I instruction words from short descriptions (kind,
// registers, funct bits, immediate) and writes them to instruction memory at
// consecutive word addresses. It is used to load a test program into imem
// while the core is held in reset. Supported classes: lw, sw, R-type, beq,
// I-type ALU (including shifts) and jal.
//
// Ports:
//   clk, reset           clock; synchronous active-high reset
//   start                begin/restart a session (count and error cleared)
//   finish               end the session, return to idle
//   in_valid / in_ready  handshake for one instruction description
//   in_kind              0 lw, 1 sw, 2 R, 3 beq, 4 I-ALU, 5 jal, 6-7 illegal
//   in_funct3            funct3 field
//   in_funct7b5          funct7[5] (sub/sra/srai)
//   in_rd/in_rs1/in_rs2  register numbers
//   in_imm               signed immediate (byte offset for beq/jal)
//   imem_we              one-cycle write strobe per emitted word
//   imem_addr            BASE_ADDR + 4*count
//   imem_wd              encoded instruction word
//   count                words written in this session (saturates at DEPTH)
//   busy                 session active
//   err / err_code       sticky error flag and first error cause
//                        (1 illegal kind, 2 imm out of range, 3 imm odd)
// -----------------------------------------------------------------------------
module instr_encoder_loader #(
    parameter int          DEPTH     = 64,
    parameter int          ADDR_W    = 6,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               finish,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         in_kind,
    input  logic [2:0]         in_funct3,
    input  logic               in_funct7b5,
    input  logic [4:0]         in_rd,
    input  logic [4:0]         in_rs1,
    input  logic [4:0]         in_rs2,
    input  logic signed [20:0] in_imm,
    output logic               imem_we,
    output logic [31:0]        imem_addr,
    output logic [31:0]        imem_wd,
    output logic [ADDR_W:0]    count,
    output logic               busy,
    output logic               err,
    output logic [1:0]         err_code
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_EMIT = 2'd2
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    state_t          state_q, state_d;
    logic [ADDR_W:0] count_q, count_d;
    logic            err_q, err_d;
    logic [1:0]      code_q, code_d;
    logic            we_q, we_d;
    logic [31:0]     wd_q, wd_d;
    logic [1:0]      chk_code;
    logic [31:0]     enc_word;
    logic            accept;

    // Immediate legality: range is tested before alignment, so an odd value
    // that is also out of range reports code 2.
    function automatic logic [1:0] imm_check(input logic [2:0] kind,
                                             input logic [2:0] f3,
                                             input logic signed [20:0] imm);
        logic [1:0] code;
        code = 2'd0;
        case (kind)
            3'd0, 3'd1: begin
                if (imm < -21'sd2048 || imm > 21'sd2047) code = 2'd2;
            end
            3'd2: code = 2'd0;
            3'd3: begin
                if (imm < -21'sd4096 || imm > 21'sd4094) code = 2'd2;
                else if (imm[0])                         code = 2'd3;
            end
            3'd4: begin
                if (f3 == 3'b001 || f3 == 3'b101) begin
                    if (imm < 21'sd0 || imm > 21'sd31) code = 2'd2;
                end else if (imm < -21'sd2048 || imm > 21'sd2047) begin
                    code = 2'd2;
                end
            end
            // The lower jal bound equals the 21-bit minimum, so only the top
            // bound can be violated.
            3'd5: begin
                if (imm > 21'sd1048574) code = 2'd2;
                else if (imm[0])        code = 2'd3;
            end
            default: code = 2'd1;
        endcase
        return code;
    endfunction

    function automatic logic [31:0] encode(input logic [2:0] kind,
                                           input logic [2:0] f3,
                                           input logic f7b5,
                                           input logic [4:0] rd,
                                           input logic [4:0] rs1,
                                           input logic [4:0] rs2,
                                           input logic signed [20:0] imm);
        logic [31:0] w;
        w = 32'h0;
        case (kind)
            3'd0: w = {imm[11:0], rs1, f3, rd, 7'b0000011};
            3'd1: w = {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
            3'd2: w = {1'b0, f7b5, 5'b00000, rs2, rs1, f3, rd, 7'b0110011};
            3'd3: w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11],
                       7'b1100011};
            3'd4: begin
                if (f3 == 3'b001 || f3 == 3'b101)
                    w = {1'b0, f7b5, 5'b00000, imm[4:0], rs1, f3, rd, 7'b0010011};
                else
                    w = {imm[11:0], rs1, f3, rd, 7'b0010011};
            end
            3'd5: w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
            default: w = 32'h0;
        endcase
        return w;
    endfunction

    assign chk_code = imm_check(in_kind, in_funct3, in_imm);
    assign enc_word = encode(in_kind, in_funct3, in_funct7b5, in_rd, in_rs1,
                             in_rs2, in_imm);
    assign in_ready = (state_q == ST_LOAD) && (count_q < DEPTH_C);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        err_d   = err_q;
        code_d  = code_q;
        we_d    = 1'b0;
        wd_d    = wd_q;
        case (state_q)
            ST_IDLE: state_d = ST_IDLE;
            ST_LOAD: begin
                if (accept) begin
                    if (chk_code == 2'd0) begin
                        state_d = ST_EMIT;
                        we_d    = 1'b1;
                        wd_d    = enc_word;
                    end else begin
                        // Bad descriptions are consumed without a write.
                        err_d = 1'b1;
                        if (!err_q) code_d = chk_code;
                    end
                end else if (finish) begin
                    state_d = ST_IDLE;
                end
            end
            // The strobe is high for this whole cycle, so the address still
            // reflects the old count; the increment lands at its end.
            ST_EMIT: begin
                state_d = ST_LOAD;
                count_d = count_q + 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
        // start overrides everything; a write already on the bus in EMIT has
        // its strobe this cycle and is not affected.
        if (start) begin
            state_d = ST_LOAD;
            count_d = '0;
            err_d   = 1'b0;
            code_d  = 2'd0;
            we_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            err_q   <= 1'b0;
            code_q  <= 2'd0;
            we_q    <= 1'b0;
            wd_q    <= 32'h0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            err_q   <= err_d;
            code_q  <= code_d;
            we_q    <= we_d;
            wd_q    <= wd_d;
        end
    end

    assign imem_we   = we_q;
    assign imem_wd   = wd_q;
    assign imem_addr = BASE_ADDR + {{(32-ADDR_W-3){1'b0}}, count_q, 2'b00};
    assign count     = count_q;
    assign busy      = (state_q != ST_IDLE);
    assign err       = err_q;
    assign err_code  = code_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// -----------------------------------------------------------------------------
// tb_instr_encoder_loader
//
// Bench for instr_encoder_loader with DEPTH=4. Expected words are built from
// the RV32I field layout with integer shifts; expected count/error state is
// tracked with plain integers.
// -----------------------------------------------------------------------------
module tb_instr_encoder_loader;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic               finish;
    logic               in_valid;
    logic               in_ready;
    logic [2:0]         in_kind;
    logic [2:0]         in_funct3;
    logic               in_funct7b5;
    logic [4:0]         in_rd;
    logic [4:0]         in_rs1;
    logic [4:0]         in_rs2;
    logic signed [20:0] in_imm;
    logic               imem_we;
    logic [31:0]        imem_addr;
    logic [31:0]        imem_wd;
    logic [ADDR_W:0]    count;
    logic               busy;
    logic               err;
    logic [1:0]         err_code;

    int total = 0;
    int bad   = 0;
    int m_count = 0;
    int m_err   = 0;
    int m_code  = 0;

    instr_encoder_loader #(
        .DEPTH     (DEPTH),
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (32'h0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .finish      (finish),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_kind     (in_kind),
        .in_funct3   (in_funct3),
        .in_funct7b5 (in_funct7b5),
        .in_rd       (in_rd),
        .in_rs1      (in_rs1),
        .in_rs2      (in_rs2),
        .in_imm      (in_imm),
        .imem_we     (imem_we),
        .imem_addr   (imem_addr),
        .imem_wd     (imem_wd),
        .count       (count),
        .busy        (busy),
        .err         (err),
        .err_code    (err_code)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Field v[hi:lo] placed at bit position pos.
    function automatic logic [31:0] fld(input int v, input int hi, input int lo,
                                        input int pos);
        longint m;
        m = (longint'(v) >>> lo) & ((64'sd1 <<< (hi - lo + 1)) - 64'sd1);
        return 32'(m <<< pos);
    endfunction

    function automatic int ref_code(input int k, input int f3, input int imm);
        if (k > 5) return 1;
        case (k)
            0, 1: return (imm < -2048 || imm > 2047) ? 2 : 0;
            2:    return 0;
            3: begin
                if (imm < -4096 || imm > 4094) return 2;
                if (imm % 2 != 0) return 3;
                return 0;
            end
            4: begin
                if (f3 == 1 || f3 == 5) return (imm < 0 || imm > 31) ? 2 : 0;
                return (imm < -2048 || imm > 2047) ? 2 : 0;
            end
            default: begin
                if (imm < -1048576 || imm > 1048574) return 2;
                if (imm % 2 != 0) return 3;
                return 0;
            end
        endcase
    endfunction

    function automatic logic [31:0] ref_word(input int k, input int f3,
                                             input int f7, input int rd,
                                             input int rs1, input int rs2,
                                             input int imm);
        logic [31:0] regs;
        regs = fld(rs1, 4, 0, 15) | fld(f3, 2, 0, 12);
        case (k)
            0: return fld(imm, 11, 0, 20) | regs | fld(rd, 4, 0, 7) | 32'h03;
            1: return fld(imm, 11, 5, 25) | fld(rs2, 4, 0, 20) | regs
                      | fld(imm, 4, 0, 7) | 32'h23;
            2: return fld(f7, 0, 0, 30) | fld(rs2, 4, 0, 20) | regs
                      | fld(rd, 4, 0, 7) | 32'h33;
            3: return fld(imm, 12, 12, 31) | fld(imm, 10, 5, 25)
                      | fld(rs2, 4, 0, 20) | regs | fld(imm, 4, 1, 8)
                      | fld(imm, 11, 11, 7) | 32'h63;
            4: begin
                if (f3 == 1 || f3 == 5)
                    return fld(f7, 0, 0, 30) | fld(imm, 4, 0, 20) | regs
                           | fld(rd, 4, 0, 7) | 32'h13;
                return fld(imm, 11, 0, 20) | regs | fld(rd, 4, 0, 7) | 32'h13;
            end
            default: return fld(imm, 20, 20, 31) | fld(imm, 10, 1, 21)
                            | fld(imm, 11, 11, 20) | fld(imm, 19, 12, 12)
                            | fld(rd, 4, 0, 7) | 32'h6F;
        endcase
    endfunction

    task automatic drive_desc(input int k, input int f3, input int f7,
                              input int rd, input int rs1, input int rs2,
                              input int imm);
        in_kind     = 3'(k);
        in_funct3   = 3'(f3);
        in_funct7b5 = 1'(f7);
        in_rd       = 5'(rd);
        in_rs1      = 5'(rs1);
        in_rs2      = 5'(rs2);
        in_imm      = 21'(imm);
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
        m_count = 0;
        m_err   = 0;
        m_code  = 0;
        chk("start_count", 32'(count), 32'd0);
        chk("start_err", {err_code, err}, 32'd0);
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_ready", 32'(in_ready), 32'd1);
    endtask

    // One handshake with a session in LOAD and room left.
    task automatic xact(input int k, input int f3, input int f7, input int rd,
                        input int rs1, input int rs2, input int imm,
                        input bit fin);
        int code;
        logic [31:0] w;
        code = ref_code(k, f3, imm);
        w    = ref_word(k, f3, f7, rd, rs1, rs2, imm);
        drive_desc(k, f3, f7, rd, rs1, rs2, imm);
        chk("ready_before", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        finish   = fin;
        step();
        in_valid = 1'b0;
        finish   = 1'b0;
        if (code == 0) begin
            chk("we_emit", 32'(imem_we), 32'd1);
            chk("wd", imem_wd, w);
            chk("addr", imem_addr, 32'(4 * m_count));
            chk("ready_emit", 32'(in_ready), 32'd0);
            step();
            m_count++;
            chk("we_after", 32'(imem_we), 32'd0);
            chk("count", 32'(count), 32'(m_count));
            chk("ready_after", 32'(in_ready), 32'(m_count < DEPTH));
        end else begin
            m_err = 1;
            if (m_code == 0) m_code = code;
            chk("we_bad", 32'(imem_we), 32'd0);
            chk("err", 32'(err), 32'(m_err));
            chk("err_code", 32'(err_code), 32'(m_code));
            chk("count_bad", 32'(count), 32'(m_count));
            chk("ready_bad", 32'(in_ready), 32'd1);
        end
    endtask

    int edges [15] = '{-4096, -4095, -2049, -2048, 2047, 2048, 4094, 4095,
                       -1048576, 1048574, 1048575, 31, 32, -1, 0};

    initial begin
        int k, f3, imm, wait_n;
        reset = 1'b1; start = 1'b0; finish = 1'b0; in_valid = 1'b0;
        drive_desc(0, 0, 0, 0, 0, 0, 0);
        step(); step();
        reset = 1'b0;
        step();
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_we", 32'(imem_we), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", {err_code, err}, 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_wd", imem_wd, 32'h0);

        // Reference examples; four words fill the DEPTH=4 session.
        do_start();
        xact(0, 2, 0, 6, 9, 0, -4, 1'b0);
        chk("lw_word", imem_wd, 32'hFFC4A303);
        xact(1, 2, 0, 0, 9, 6, 8, 1'b0);
        chk("sw_word", imem_wd, 32'h0064A423);
        xact(2, 0, 1, 5, 6, 7, 0, 1'b0);
        chk("r_word", imem_wd, 32'h407302B3);
        xact(3, 0, 0, 0, 4, 4, 16, 1'b0);
        chk("beq_word", imem_wd, 32'h00420863);

        // Full: further requests are refused.
        drive_desc(5, 0, 0, 1, 0, 0, 8);
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("full_ready", 32'(in_ready), 32'd0);
            chk("full_we", 32'(imem_we), 32'd0);
            chk("full_count", 32'(count), 32'd4);
        end
        in_valid = 1'b0;
        do_start();
        xact(5, 0, 0, 1, 0, 0, 8, 1'b0);
        chk("jal_word", imem_wd, 32'h008000EF);

        // Errors: first code is kept.
        xact(3, 0, 0, 0, 4, 4, 3, 1'b0);
        xact(6, 0, 0, 0, 0, 0, 0, 1'b0);
        do_start();
        xact(5, 0, 0, 1, 0, 0, 1048575, 1'b0);

        // Randomized descriptions.
        for (int n = 0; n < 40; n++) begin
            if (m_count == DEPTH || n % 10 == 9) do_start();
            k  = int'($urandom_range(0, 7));
            f3 = int'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0: imm = int'($urandom_range(0, 80)) - 40;
                1: imm = edges[$urandom_range(0, 14)];
                2: imm = int'($urandom_range(0, 2097151)) - 1048576;
                default: imm = int'($urandom_range(0, 31));
            endcase
            xact(k, f3, int'($urandom_range(0, 1)), int'($urandom_range(0, 31)),
                 int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                 imm, 1'b0);
        end

        // finish with a handshake is ignored; finish alone ends the session.
        do_start();
        xact(4, 0, 0, 3, 2, 0, -100, 1'b1);
        chk("fin_hs_busy", 32'(busy), 32'd1);
        finish = 1'b1;
        step();
        finish = 1'b0;
        chk("fin_busy", 32'(busy), 32'd0);
        chk("fin_ready", 32'(in_ready), 32'd0);

        // start during EMIT: strobe completes, count returns to 0.
        do_start();
        xact(2, 0, 0, 1, 2, 3, 0, 1'b0);
        drive_desc(4, 1, 1, 7, 8, 0, 5);
        in_valid = 1'b1;
        wait_n = 0;
        while (!in_ready && wait_n < 10) begin
            step();
            wait_n++;
        end
        chk("emit_rs_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        start = 1'b1;
        chk("emit_rs_we", 32'(imem_we), 32'd1);
        chk("emit_rs_addr", imem_addr, 32'h4);
        chk("emit_rs_wd", imem_wd, ref_word(4, 1, 1, 7, 8, 0, 5));
        step();
        start = 1'b0;
        m_count = 0;
        chk("emit_rs_we0", 32'(imem_we), 32'd0);
        chk("emit_rs_count", 32'(count), 32'd0);
        chk("emit_rs_busy", 32'(busy), 32'd1);

        // reset at the handshake edge drops the write.
        drive_desc(0, 2, 0, 1, 1, 0, 4);
        in_valid = 1'b1;
        reset = 1'b1;
        step();
        in_valid = 1'b0;
        reset = 1'b0;
        chk("rst_mid_we", 32'(imem_we), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_count", 32'(count), 32'd0);
        step();
        chk("rst_mid_we2", 32'(imem_we), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
